// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: two-port arbiter in front of a single-port registered RAM.
// Ports A and B each issue read or write commands. Only one command is in
// flight at a time. When both ports request together, the port that was not
// served most recently wins.
//   clk, reset      : clock; synchronous active-low reset
//   a_*/b_* req/we/addr/wdata : requester commands (held until gnt)
//   a_*/b_* gnt/rvalid/rdata  : grant pulse, read-valid pulse, held read data
//   ram_wr/ram_rd/ram_addr/ram_data/ram_dout : RAM side (dout is 1-cycle latency)
//   busy            : arbiter is not idle
module ram_arbiter_2p #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_e;

  state_e              state_q, state_d;
  logic                win_q, win_d;     // 0 = A, 1 = B
  logic                last_q, last_d;   // last served port, 0 = A, 1 = B
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic                sel_b;

  // Under contention the port not served last wins; otherwise the sole requester.
  assign sel_b = (a_req && b_req) ? ~last_q : b_req;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          win_d   = sel_b;
          last_d  = sel_b;
          we_d    = sel_b ? b_we    : a_we;
          addr_d  = sel_b ? b_addr  : a_addr;
          data_d  = sel_b ? b_wdata : a_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = we_q ? IDLE : RDWAIT;
      RDWAIT: begin
        // RAM output is valid this cycle; the rvalid pulse follows next cycle
        if (win_q) b_rdata_d = ram_dout;
        else       a_rdata_d = ram_dout;
        a_rvalid_d = ~win_q;
        b_rvalid_d = win_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      last_q     <= 1'b1;  // B served last, so A wins first contention
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Latched command only changes on the IDLE->ISSUE edge, so the RAM address
  // and data naturally hold their last value outside ISSUE.
  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign ram_wr   = (state_q == ISSUE) &&  we_q;
  assign ram_rd   = (state_q == ISSUE) && !we_q;
  assign a_gnt    = (state_q == ISSUE) && !win_q;
  assign b_gnt    = (state_q == ISSUE) &&  win_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule
